seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector with Moore-style registered output.
- Generalises the fixed "1001" overlapping detector:
  - pattern up to MAX_LEN bits, programmed at runtime;
  - length programmed at runtime;
  - overlapping/non-overlapping mode selectable;
  - input qualifier (in_valid);
  - saturating match counter.
- Sits in the sequential_circuit/FSM library as the general serial-framing/sync-word detector.
- Reset defaults reproduce the legacy 1001 overlapping behaviour.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- DEF_PATTERN, 8'b0000_1001, pattern loaded at reset (LSB-aligned, width MAX_LEN).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.
- CNT_W, 16, match counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- in_valid  in  1  x sampled only when high.
- cfg_load  in  1  latch cfg_* and restart detection.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; 0 disables detection.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  one-cycle match pulse, registered.
- busy  out  1  high in FILL or RUN states.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset is asynchronous (rst, active-high); clock is clk.
- Reset values:
  - match=0, match_cnt=0, busy=0 (busy rises in FILL after reset when DEF_LEN≠0);
  - history=0, fill=0;
  - pattern/len/overlap = DEF_*.
- History register hist[MAX_LEN-1:0]: on an accepted bit (in_valid=1, cfg_load=0), hist <= {hist[MAX_LEN-2:0], x}.
- fill counter: increments on each accepted bit, saturating at len.
- Three-state FSM:
  - IDLE (len=0);
  - FILL (fill < len);
  - RUN (fill == len).
- Transitions:
  - IDLE: stays until cfg_load with cfg_len≠0 → FILL.
  - FILL → RUN when an accepted bit makes fill reach len.
  - RUN: on an accepted bit, evaluate hist_next[len-1:0] == pattern[len-1:0].
  - Any state: cfg_load → FILL (cfg_len≠0) or IDLE (cfg_len=0).
  - After reset: FILL if DEF_LEN≠0, else IDLE.
- Match timing:
  - match is registered. It is 1 for exactly the cycle after the edge that accepted the completing bit; otherwise 0.
  - A single-bit pattern (len=1) is compared on every accepted bit.
- Overlap:
  - overlap=1: history and fill retained after a match. 1001001 gives matches after bits 4 and 7.
  - overlap=0: on a match, fill is cleared to 0 and FSM → FILL, so the next match needs len fresh bits. 1001001 gives a match after bit 4 only.
- in_valid=0: no shift, no compare, match=0 next cycle, state held.
- cfg_load:
  - cfg_load has priority over in_valid; a bit presented in the same cycle is dropped.
  - It clears hist, fill and match.
  - match_cnt is unaffected.
- cfg_len > MAX_LEN is clamped to MAX_LEN.
- Pattern bits above len-1 are ignored.
- match_cnt:
  - +1 on each match, saturating at 2^CNT_W-1.
  - cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-stream: all state returns to reset values immediately (asynchronous); a pending match is lost.

Optional Feature:
- SEQ_DET_CNT_EN defined: match_cnt and cnt_clr function as specified.
- Not defined: counter logic removed, match_cnt tied to 0, cnt_clr ignored. Port list is unchanged.

Decomposition:
- Package seq_det_pkg:
  - state enum {ST_IDLE, ST_FILL, ST_RUN} (2-bit encoding);
  - helper function len_clamp.
- One sub-module, seq_det_sat_cnt: saturating counter with synchronous clear and increment, parameter W.
- FSM, history and compare logic stay in the top module.

Test Plan:
- Reset defaults, stream 1,0,0,1,0,0,1 with in_valid=1 → match pulses in the cycles after bits 4 and 7; match_cnt=2.
- cfg_load pattern=0b1001, len=4, overlap=0, same stream → single pulse after bit 4; match_cnt increments by 1.
- cfg_load pattern=0b1101_0110, len=8, stream containing it twice with a 3-bit gap in_valid=0 mid-pattern → exactly two pulses, none during the gap.
- cfg_load len=0, stream all 1s → busy=0, match never asserts; then cfg_load len=1, pattern=1 → match every accepted cycle.
- cfg_load asserted with in_valid=1 on the would-be completing bit → no match; bit dropped; fill=0.
- CNT_W=2 with SEQ_DET_CNT_EN: 5 matches → match_cnt saturates at 3; cnt_clr coincident with a match → 0. rst pulsed mid-pattern → all outputs 0 asynchronously.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Limit a requested pattern length to what the history register can hold.
  function automatic int unsigned len_clamp(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Define SEQ_DET_CNT_EN to build the saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1001),
  parameter int                 DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b1,
  parameter int                 CNT_W       = 16,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LW-1:0] DEF_LEN_C = LW'(len_clamp(DEF_LEN, MAX_LEN));

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_next, len_mask;
  logic [LW-1:0]      len_q, len_d, fill_q, fill_d, cfg_len_c;
  logic               overlap_q, overlap_d, match_q, match_d, busy_q;
  logic               accept, completing, hit;

  assign accept     = in_valid & ~cfg_load;
  assign hist_next  = {hist_q[MAX_LEN-2:0], x};
  assign cfg_len_c  = LW'(len_clamp(32'(cfg_len), MAX_LEN));
  assign completing = (state_q == ST_RUN) ||
                      ((state_q == ST_FILL) && ((fill_q + LW'(1)) == len_q));
  assign hit        = ((hist_next ^ pattern_q) & len_mask) == '0;

  // Only the newest len bits take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      len_mask[i] = (i < int'(len_q));
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    match_d   = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_c;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = (cfg_len_c != '0) ? ST_FILL : ST_IDLE;
    end else if (accept) begin
      hist_d = hist_next;
      if (state_q == ST_FILL)
        fill_d = fill_q + LW'(1);
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      if (completing) begin
        state_d = ST_RUN;
        match_d = hit;
        if (hit && !overlap_q) begin
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
    end
  end

  // busy is registered so it reads 0 straight out of reset and rises a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (DEF_LEN_C != '0) ? ST_FILL : ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= DEF_LEN_C;
      overlap_q <= DEF_OVERLAP;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign match = match_q;
  assign busy  = busy_q;

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (match_d),
    .cnt_o (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised self-checking bench for seq_detector_prog against a bit-queue reference model.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               x, in_valid, cfg_load, cfg_overlap, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               match, busy;
  logic [CNT_W-1:0]   match_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: every bit accepted since the last restart, newest at the back.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_q[$];
  int                 m_cnt;
  bit                 m_match;
  bit                 m_busy_en;

  seq_detector_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .in_valid   (in_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .busy       (busy),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt();
`ifdef SEQ_DET_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_busy();
    return m_busy_en && (m_len != 0);
  endfunction

  task automatic model_reset();
    m_pat     = 8'b0000_1001;
    m_len     = 4;
    m_ovl     = 1'b1;
    m_q.delete();
    m_cnt     = 0;
    m_match   = 1'b0;
    m_busy_en = 1'b0;
  endtask

  // One clock: present x/in_valid (cfg_load/cnt_clr set by caller), advance model, settle.
  task automatic drive(input bit b, input bit v);
    bit hit;
    x        = b;
    in_valid = v;
    @(posedge clk);
    hit       = 1'b0;
    m_busy_en = 1'b1;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      m_ovl = cfg_overlap;
      m_q.delete();
    end else if (v) begin
      m_q.push_back(int'(b));
      if (m_q.size() > 64) void'(m_q.pop_front());
      if (m_len != 0 && m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int j = 0; j < m_len; j++)
          if (m_q[m_q.size() - 1 - j] != int'(m_pat[j])) hit = 1'b0;
      end
      if (hit && !m_ovl) m_q.delete();
    end
    m_match = hit;
    if (cnt_clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    #1;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    x        = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len, input bit ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    drive(1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", match); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (match_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b want=0", busy); end
    drive(1'b0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%b want=1", busy); end
  endtask

  task automatic test_legacy_overlap();
    bit s [7] = '{1, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      drive(s[i], 1'b1);
      total++; if (match !== m_match) begin bad++; $display("FAIL legacy_model bit=%0d got=%b want=%b", i, match, m_match); end
      total++; if (match !== ((i == 3) || (i == 6))) begin bad++; $display("FAIL legacy_fixed bit=%0d got=%b", i, match); end
    end
    total++; if (int'(match_cnt) != exp_cnt()) begin bad++; $display("FAIL legacy_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_non_overlap();
    bit s [7] = '{1, 0, 0, 1, 0, 0, 1};
    do_load(8'b0000_1001, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(s[i], 1'b1);
      total++; if (match !== (i == 3)) begin bad++; $display("FAIL nonovl bit=%0d got=%b want=%b", i, match, (i == 3)); end
    end
    total++; if (int'(match_cnt) != exp_cnt()) begin bad++; $display("FAIL nonovl_cnt got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_gap_len8();
    logic [7:0] p = 8'b1101_0110;
    int pulses = 0;
    do_load(p, 4'd8, 1'b0);
    for (int copy = 0; copy < 2; copy++) begin
      for (int i = 7; i >= 0; i--) begin
        drive(p[i], 1'b1);
        total++; if (match !== m_match) begin bad++; $display("FAIL gap_model copy=%0d bit=%0d got=%b want=%b", copy, i, match, m_match); end
        if (match === 1'b1) pulses++;
        if (i == 3) begin
          for (int g = 0; g < 3; g++) begin
            drive(1'($urandom), 1'b0);
            total++; if (match !== 1'b0) begin bad++; $display("FAIL gap_idle copy=%0d got=%b want=0", copy, match); end
          end
        end
      end
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL gap_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_len_zero_and_one();
    do_load(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b want=0", busy); end
      total++; if (match !== 1'b0) begin bad++; $display("FAIL len0_match got=%b want=0", match); end
    end
    do_load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      total++; if (match !== 1'b1) begin bad++; $display("FAIL len1_match cyc=%0d got=%b want=1", i, match); end
    end
    drive(1'b1, 1'b0);
    total++; if (match !== 1'b0) begin bad++; $display("FAIL len1_novalid got=%b want=0", match); end
    drive(1'b0, 1'b1);
    total++; if (match !== 1'b0) begin bad++; $display("FAIL len1_zero got=%b want=0", match); end
  endtask

  task automatic test_load_drop();
    bit s [4] = '{1, 0, 0, 1};
    do_load(8'b0000_1001, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) drive(s[i], 1'b1);
    cfg_pattern = 8'b0000_1001; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_load = 1'b1;
    drive(1'b1, 1'b1);
    total++; if (match !== 1'b0) begin bad++; $display("FAIL drop_match got=%b want=0", match); end
    for (int i = 0; i < 4; i++) begin
      drive(s[i], 1'b1);
      total++; if (match !== (i == 3)) begin bad++; $display("FAIL drop_refill bit=%0d got=%b want=%b", i, match, (i == 3)); end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] p = 8'hA5;
    do_load(p, 4'd12, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      drive(p[i], 1'b1);
      total++; if (match !== (i == 0)) begin bad++; $display("FAIL clamp bit=%0d got=%b want=%b", i, match, (i == 0)); end
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    do_load(8'h01, 4'd1, 1'b1);
    total++; if (match_cnt !== '0) begin bad++; $display("FAIL cnt_clear got=%0d want=0", match_cnt); end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
`ifdef SEQ_DET_CNT_EN
    total++; if (match_cnt !== 2'd3) begin bad++; $display("FAIL cnt_sat got=%0d want=3", match_cnt); end
`else
    total++; if (match_cnt !== 2'd0) begin bad++; $display("FAIL cnt_tied got=%0d want=0", match_cnt); end
`endif
    cnt_clr = 1'b1;
    drive(1'b1, 1'b1);
    total++; if (match !== 1'b1) begin bad++; $display("FAIL clr_match got=%b want=1", match); end
    total++; if (match_cnt !== '0) begin bad++; $display("FAIL clr_wins got=%0d want=0", match_cnt); end
    drive(1'b1, 1'b1);
    total++; if (int'(match_cnt) != exp_cnt()) begin bad++; $display("FAIL cnt_after_clr got=%0d want=%0d", match_cnt, exp_cnt()); end
  endtask

  task automatic test_reset_mid();
    bit s [4] = '{1, 0, 0, 1};
    do_load(8'b0000_1001, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) drive(s[i], 1'b1);
    total++; if (match !== 1'b1) begin bad++; $display("FAIL pre_reset_match got=%b want=1", match); end
    #1 rst = 1'b1;
    #1;
    total++; if (match !== 1'b0) begin bad++; $display("FAIL async_match got=%b want=0", match); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
    total++; if (match_cnt !== '0) begin bad++; $display("FAIL async_cnt got=%0d want=0", match_cnt); end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i], 1'b1);
      total++; if (match !== (i == 3)) begin bad++; $display("FAIL post_reset bit=%0d got=%b want=%b", i, match, (i == 3)); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [7:0] p   = 8'($urandom);
      logic [3:0] l   = 4'($urandom_range(0, 10));
      int         eff = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      int         idx = 0;
      do_load(p, l, 1'($urandom));
      for (int c = 0; c < 150; c++) begin
        bit b;
        bit v = ($urandom_range(0, 9) < 8);
        b = (eff != 0 && $urandom_range(0, 9) < 9) ? p[eff - 1 - idx] : 1'($urandom);
        if (v && eff != 0) idx = (idx + 1) % eff;
        cnt_clr = ($urandom_range(0, 49) == 0);
        drive(b, v);
        total++; if (match !== m_match) begin bad++; $display("FAIL rnd_match r=%0d c=%0d got=%b want=%b", r, c, match, m_match); end
        total++; if (busy !== exp_busy()) begin bad++; $display("FAIL rnd_busy r=%0d c=%0d got=%b want=%b", r, c, busy, exp_busy()); end
        total++; if (int'(match_cnt) != exp_cnt()) begin bad++; $display("FAIL rnd_cnt r=%0d c=%0d got=%0d want=%0d", r, c, match_cnt, exp_cnt()); end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    x           = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    model_reset();
    test_reset();
    test_legacy_overlap();
    test_non_overlap();
    test_gap_len8();
    test_len_zero_and_one();
    test_load_drop();
    test_clamp();
    test_counter();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
